// File: rtl/tdm_demux.sv
// Purpose: 1-to-4 TDM demultiplexer; rebuilds four frame-coherent lanes from a SYNC-framed serial stream.
// Latency: lanes and FRAME_DONE update on the edge that accepts the slot-3 sample (visible the next cycle).
// Backpressure: none; IN_VALID qualifies samples, idle gaps of any length are tolerated.
module tdm_demux #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_in_valid,
    input  logic             i_sync,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_c,
    output logic [WIDTH-1:0] o_d,
    output logic             o_s1,
    output logic             o_s0,
    output logic             o_frame_done,
    output logic             o_locked,
    output logic             o_sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_cnt;
    logic [1:0]       w_cnt_nxt;
    logic [WIDTH-1:0] r_sh0;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] r_sh2;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_d;
    logic             r_frame_done;
    logic             r_sync_err;
    logic             w_sh_we;
    logic [1:0]       w_sh_idx;
    logic             w_load;
    logic             w_err;

    // Next-state: framing decisions made only on sample cycles; a SYNC always restarts at slot 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sh_we     = 1'b0;
        w_sh_idx    = 2'd0;
        w_load      = 1'b0;
        w_err       = 1'b0;
        if (i_in_valid) begin
            case (r_state)
                HUNT: begin
                    if (i_sync) begin
                        w_sh_we     = 1'b1;
                        w_cnt_nxt   = 2'd1;
                        w_state_nxt = LOCK;
                    end
                end
                LOCK: begin
                    if (r_cnt == 2'd0) begin
                        if (i_sync) begin
                            w_sh_we   = 1'b1;
                            w_cnt_nxt = 2'd1;
                        end else begin
                            // Missing SYNC where slot A was expected: framing lost.
                            w_err       = 1'b1;
                            w_cnt_nxt   = 2'd0;
                            w_state_nxt = HUNT;
                        end
                    end else if (i_sync) begin
                        // Early SYNC: drop the partial frame, treat this sample as slot A.
                        w_err     = 1'b1;
                        w_sh_we   = 1'b1;
                        w_cnt_nxt = 2'd1;
                    end else if (r_cnt == 2'd3) begin
                        w_load    = 1'b1;
                        w_cnt_nxt = 2'd0;
                    end else begin
                        w_sh_we   = 1'b1;
                        w_sh_idx  = r_cnt;
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // State register, slot counter and single-cycle status pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= HUNT;
            r_cnt        <= 2'd0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_frame_done <= w_load;
            r_sync_err   <= w_err;
        end
    end

    // Shadow capture of slots 0..2; slot 3 bypasses the shadow straight into lane D.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh0 <= '0;
            r_sh1 <= '0;
            r_sh2 <= '0;
        end else if (w_sh_we) begin
            case (w_sh_idx)
                2'd0:    r_sh0 <= i_in;
                2'd1:    r_sh1 <= i_in;
                2'd2:    r_sh2 <= i_in;
                default: r_sh0 <= r_sh0;
            endcase
        end
    end

    // Lanes load together, only when a complete frame has arrived.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
            r_d <= '0;
        end else if (w_load) begin
            r_a <= r_sh0;
            r_b <= r_sh1;
            r_c <= r_sh2;
            r_d <= i_in;
        end
    end

    assign o_a          = r_a;
    assign o_b          = r_b;
    assign o_c          = r_c;
    assign o_d          = r_d;
    assign o_s1         = r_cnt[1];
    assign o_s0         = r_cnt[0];
    assign o_frame_done = r_frame_done;
    assign o_sync_err   = r_sync_err;
    assign o_locked     = (r_state == LOCK);

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed vector table, hand-written corner sequences,
// then random traffic against a frame-queue reference model.
module tb_tdm_demux;

    logic       clk;
    logic       rst_n;
    logic [0:0] in_dat;
    logic       in_vld;
    logic       sync;
    logic [0:0] a, b, c, d;
    logic       s1, s0, frame_done, locked, sync_err;

    int errors = 0;
    int checks = 0;

    tdm_demux #(.WIDTH(1)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in         (in_dat),
        .i_in_valid   (in_vld),
        .i_sync       (sync),
        .o_a          (a),
        .o_b          (b),
        .o_c          (c),
        .o_d          (d),
        .o_s1         (s1),
        .o_s0         (s0),
        .o_frame_done (frame_done),
        .o_locked     (locked),
        .o_sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       v;
        logic       s;
        logic       din;
        logic [3:0] abcd;
        logic [1:0] st;
        logic       done;
        logic       err;
        logic       lk;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string n, input logic v, input logic s, input logic din,
                                input logic [3:0] abcd, input logic [1:0] st,
                                input logic done, input logic err, input logic lk);
        vec_t e;
        e.name = n; e.v = v; e.s = s; e.din = din; e.abcd = abcd;
        e.st = st; e.done = done; e.err = err; e.lk = lk;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic chk_all(input string n, input logic [3:0] abcd, input logic [1:0] st,
                           input logic done, input logic err, input logic lk);
        chk({n, ".abcd"}, {a, b, c, d}, abcd);
        chk({n, ".slot"}, {s1, s0}, st);
        chk({n, ".done"}, frame_done, done);
        chk({n, ".err"}, sync_err, err);
        chk({n, ".lock"}, locked, lk);
    endtask

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic s, input logic din);
        in_vld = v; sync = s; in_dat = din;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_vld = 0; sync = 0; in_dat = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a partial-frame queue; its length is the expected next slot.
    bit         m_locked;
    logic       m_part[$];
    logic [3:0] m_abcd;
    logic       m_done, m_err;

    function automatic void m_reset();
        m_locked = 0; m_part.delete(); m_abcd = 4'h0; m_done = 0; m_err = 0;
    endfunction

    function automatic void m_sample(input logic v, input logic s, input logic din);
        m_done = 0; m_err = 0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin m_part.delete(); m_part.push_back(din); m_locked = 1; end
        end else if (s) begin
            if (m_part.size() != 0) m_err = 1;
            m_part.delete(); m_part.push_back(din);
        end else if (m_part.size() == 0) begin
            m_err = 1; m_locked = 0;
        end else begin
            m_part.push_back(din);
            if (m_part.size() == 4) begin
                m_abcd = {m_part[0], m_part[1], m_part[2], m_part[3]};
                m_done = 1;
                m_part.delete();
            end
        end
    endfunction

    initial begin
        rst_n = 1; in_vld = 0; sync = 0; in_dat = 0;
        #2 rst_n = 0;
        #1;
        chk_all("reset", 4'h0, 2'd0, 0, 0, 0);
        do_reset();
        chk_all("post_reset", 4'h0, 2'd0, 0, 0, 0);

        // Two back-to-back frames, early sync, missing sync, then hunting.
        add("t2_s0",  1, 1, 0, 4'b0000, 2'd1, 0, 0, 1);
        add("t2_s1",  1, 0, 1, 4'b0000, 2'd2, 0, 0, 1);
        add("t2_s2",  1, 0, 0, 4'b0000, 2'd3, 0, 0, 1);
        add("t2_s3",  1, 0, 1, 4'b0101, 2'd0, 1, 0, 1);
        add("t2_idle",0, 0, 0, 4'b0101, 2'd0, 0, 0, 1);
        add("t2b_s0", 1, 1, 1, 4'b0101, 2'd1, 0, 0, 1);
        add("t2b_s1", 1, 0, 0, 4'b0101, 2'd2, 0, 0, 1);
        add("t2b_s2", 1, 0, 1, 4'b0101, 2'd3, 0, 0, 1);
        add("t2b_s3", 1, 0, 0, 4'b1010, 2'd0, 1, 0, 1);
        add("t5_s0",  1, 1, 1, 4'b1010, 2'd1, 0, 0, 1);
        add("t5_s1",  1, 0, 1, 4'b1010, 2'd2, 0, 0, 1);
        add("t5_early",1,1, 0, 4'b1010, 2'd1, 0, 1, 1);
        add("t5_s1b", 1, 0, 1, 4'b1010, 2'd2, 0, 0, 1);
        add("t5_s2b", 1, 0, 1, 4'b1010, 2'd3, 0, 0, 1);
        add("t5_s3b", 1, 0, 1, 4'b0111, 2'd0, 1, 0, 1);
        add("t6_nosync",1,0,1, 4'b0111, 2'd0, 0, 1, 0);
        add("t3_h0",  1, 0, 1, 4'b0111, 2'd0, 0, 0, 0);
        add("t3_h1",  1, 0, 0, 4'b0111, 2'd0, 0, 0, 0);
        add("t3_h2",  1, 0, 1, 4'b0111, 2'd0, 0, 0, 0);
        add("t3_idle",0, 1, 1, 4'b0111, 2'd0, 0, 0, 0);
        add("t3_sync",1, 1, 1, 4'b0111, 2'd1, 0, 0, 1);
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].s, tbl[i].din);
            chk_all(tbl[i].name, tbl[i].abcd, tbl[i].st, tbl[i].done, tbl[i].err, tbl[i].lk);
        end

        // Asynchronous reset mid-cycle clears lanes and lock immediately.
        #3 rst_n = 0;
        #1;
        chk_all("t1_async", 4'h0, 2'd0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // Frame 1,0,0,1 with 5 idle cycles between samples.
        begin
            logic [3:0] pat;
            pat = 4'b1001;
            for (int k = 0; k < 4; k++) begin
                step(1, k == 0, pat[3-k]);
                for (int g = 0; g < 5; g++) begin
                    step(0, 0, 1);
                    chk($sformatf("t4_gap%0d_%0d.slot", k, g), {s1, s0}, (k + 1) % 4);
                    chk($sformatf("t4_gap%0d_%0d.done", k, g), frame_done, 0);
                    chk($sformatf("t4_gap%0d_%0d.abcd", k, g), {a, b, c, d}, (k == 3) ? pat : 4'h0);
                end
            end
            // Re-run the last sample's edge check via a fresh frame without gaps.
            step(1, 1, 0); step(1, 0, 1); step(1, 0, 1); step(1, 0, 0);
            chk_all("t4_nogap", 4'b0110, 2'd0, 1, 0, 1);
        end

        // Reset after slot 2 of a partial frame: nothing reaches the lanes.
        step(1, 1, 1); step(1, 0, 1); step(1, 0, 1);
        chk("t6_partial.slot", {s1, s0}, 2'd3);
        rst_n = 0;
        #1;
        chk_all("t6_rst", 4'h0, 2'd0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1;
        step(1, 0, 1);
        chk_all("t6_after", 4'h0, 2'd0, 0, 0, 0);

        // Random traffic against the reference model, with occasional resets.
        do_reset();
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            logic v, s, dn;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 0;
                #1;
                m_reset();
                chk_all($sformatf("rnd%0d_rst", n), 4'h0, 2'd0, 0, 0, 0);
                @(posedge clk); #1;
                rst_n = 1;
            end
            v  = ($urandom_range(0, 2) != 0);
            dn = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0)
                s = $urandom_range(0, 1);
            else
                s = (m_part.size() == 0 || m_part.size() == 4);
            m_sample(v, s, dn);
            step(v, s, dn);
            chk_all($sformatf("rnd%0d", n), m_abcd, m_part.size() % 4, m_done, m_err, m_locked);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
